// File: rtl/code_conv_pkg.sv
// Shared definitions for the binary/Gray code converter pipeline.
package code_conv_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    // Widest word the helper accepts; narrower callers zero-extend and truncate.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_grp_prefix.sv
// Local prefix XOR of one GRP-bit group, running from the group MSB down.
module gray_grp_prefix #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] g,
    output logic [GRP-1:0] p
);

    always_comb begin
        p = '0;
        p[GRP-1] = g[GRP-1];
        for (int i = GRP - 2; i >= 0; i--) begin
            p[i] = p[i+1] ^ g[i];
        end
    end

endmodule

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready binary<->Gray converter; Gray->binary is split into
// per-group local prefixes (stage 1) and a cross-group parity fix-up (stage 2).
module code_conv_pipe
    import code_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    localparam int NGRP = WIDTH / GRP;

    logic             en;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] g2b;
    logic             par;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q,  s1_mode_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_mode_q,  out_mode_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        gray_grp_prefix #(.GRP(GRP)) u_pre (
            .g (in_data[k*GRP +: GRP]),
            .p (pre[k*GRP +: GRP])
        );
    end

    assign gray = WIDTH'(bin2gray(MAX_W'(in_data)));

    // Bit 0 of each local prefix is that group's parity; fold it downward.
    always_comb begin
        par = 1'b0;
        g2b = '0;
        for (int k = NGRP - 1; k >= 0; k--) begin
            g2b[k*GRP +: GRP] = s1_data_q[k*GRP +: GRP] ^ {GRP{par}};
            par = par ^ s1_data_q[k*GRP];
        end
    end

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_data_d  = out_data_q;
        if (en) begin
            s1_valid_d  = in_valid;
            s1_mode_d   = in_mode;
            s1_data_d   = (in_mode == MODE_G2B) ? pre : gray;
            out_valid_d = s1_valid_q;
            out_mode_d  = s1_mode_q;
            out_data_d  = (s1_mode_q == MODE_G2B) ? g2b : s1_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_data  = out_data_q;

endmodule
